mem_trace_recorder: RTL and testbench

- Hardware counterpart to the store-trace checker used in CPU simulation.
- Sits beside the mips core and snoops memwrite/aluout/writedata.
- Records every store as a {cycle, addr, data} entry in a FIFO and streams the entries out over a valid/ready interface, to a UART or host dump.
- Keeps cycle and retired-instruction counters for CPI, and freezes everything when the PC reaches a programmed finish address.

---
 rtl/mips_trace_pkg.sv | 13 +
 rtl/trace_fifo.sv | 56 +++++
 rtl/mem_trace_recorder.sv | 99 +++++++++
 tb/tb_mem_trace_recorder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared types and widths for the store-trace recorder.
package mips_trace_pkg;

    localparam int unsigned TRACE_CW     = 32;
    localparam int unsigned TRACE_DROP_W = 8;

    typedef struct packed {
        logic [TRACE_CW-1:0] cycle;
        logic [31:0]         addr;
        logic [31:0]         data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO with a registered head output; new entries become
// visible one cycle after the push edge.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  trace_entry_t din,
    output logic         full,
    input  logic         pop,
    output trace_entry_t dout,
    output logic         empty,
    output logic         dout_valid
);

    localparam int unsigned AW = $clog2(DEPTH);

    trace_entry_t     mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      rptr_nxt;

    assign rptr_nxt = rptr + (AW+1)'(pop);
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    // Head register only loads entries written before this edge, so a slot
    // being written right now is never read back in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            rptr       <= rptr_nxt;
            dout_valid <= (rptr_nxt != wptr);
            if (rptr_nxt != wptr) begin
                dout <= mem[rptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/mem_trace_recorder.sv
// Snoops core stores into a trace FIFO streamed over valid/ready, and keeps
// cycle/retire counters that freeze once the PC hits the finish address.
module mem_trace_recorder
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = TRACE_CW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pc,
    input  logic [31:0]             finish_pc,
    input  logic                    memwrite,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic                    retire,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW-1:0]           out_cycle,
    output logic [31:0]             out_addr,
    output logic [31:0]             out_data,
    output logic [CW-1:0]           cycle_count,
    output logic [CW-1:0]           retire_count,
    output logic                    done,
    output logic                    drained,
    output logic                    overflow,
    output logic [TRACE_DROP_W-1:0] drop_count
);

    trace_entry_t din;
    trace_entry_t head;
    logic         finish_c;
    logic         active_c;
    logic         push_req_c;
    logic         push_c;
    logic         pop_c;
    logic         full;
    logic         empty;
    logic         head_valid;

    // The finishing cycle itself is gated off, like the stopped cpu clock.
    assign finish_c   = (pc == finish_pc) && !done;
    assign active_c   = !done && !finish_c;
    assign push_req_c = active_c && memwrite;
    assign pop_c      = head_valid && out_ready;
    assign push_c     = push_req_c && (!full || pop_c);

    assign din = '{cycle: TRACE_CW'(cycle_count + CW'(1)), addr: addr, data: wdata};

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .din        (din),
        .full       (full),
        .pop        (pop_c),
        .dout       (head),
        .empty      (empty),
        .dout_valid (head_valid)
    );

    assign out_valid = head_valid;
    assign out_cycle = CW'(head.cycle);
    assign out_addr  = head.addr;
    assign out_data  = head.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count  <= '0;
            retire_count <= '0;
            done         <= 1'b0;
            drained      <= 1'b0;
            overflow     <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (finish_c) begin
                done <= 1'b1;
            end
            if (active_c) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + CW'(1);
                end
                if (retire && (retire_count != '1)) begin
                    retire_count <= retire_count + CW'(1);
                end
            end
            if (push_req_c && !push_c) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + TRACE_DROP_W'(1);
                end
            end
            drained <= done && empty;
        end
    end

endmodule

// File: tb/tb_mem_trace_recorder.sv
// Bench for mem_trace_recorder: directed scenarios plus random traffic against a queue model.
module tb_mem_trace_recorder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc;
    logic [31:0]   finish_pc;
    logic          memwrite;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          retire;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cycle;
    logic [31:0]   out_addr;
    logic [31:0]   out_data;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] retire_count;
    logic          done;
    logic          drained;
    logic          overflow;
    logic [7:0]    drop_count;

    always #5 clk = ~clk;

    mem_trace_recorder #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .finish_pc(finish_pc),
        .memwrite(memwrite), .addr(addr), .wdata(wdata), .retire(retire),
        .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
        .out_addr(out_addr), .out_data(out_data), .cycle_count(cycle_count),
        .retire_count(retire_count), .done(done), .drained(drained),
        .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] a;
        logic [31:0] d;
        int          edge_no;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] m_cycle;
    logic [31:0] m_retire;
    logic        m_done;
    logic        m_overflow;
    logic        m_drained;
    logic        m_valid;
    logic [7:0]  m_drop;
    int          edge_no;
    int          tests = 0;
    int          fails = 0;

    task automatic model_reset();
        mq.delete();
        m_cycle = 0; m_retire = 0; m_done = 0; m_overflow = 0;
        m_drained = 0; m_valid = 0; m_drop = 0; edge_no = 0;
    endtask

    // One rising edge of the reference: queue semantics, entry visible one edge after its push.
    task automatic model_step();
        logic pop, fin, act, was_empty, old_done, is_full;
        edge_no++;
        pop       = m_valid && out_ready;
        fin       = (pc == finish_pc) && !m_done;
        act       = !m_done && !fin;
        was_empty = (mq.size() == 0);
        old_done  = m_done;
        is_full   = (mq.size() == DEPTH);
        if (pop) mq.delete(0);
        if (act && memwrite) begin
            if (is_full && !pop) begin
                m_overflow = 1;
                if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            end else begin
                mq.push_back('{m_cycle + 32'd1, addr, wdata, edge_no});
            end
        end
        if (act) begin
            if (m_cycle != 32'hFFFF_FFFF) m_cycle = m_cycle + 32'd1;
            if (retire && m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 32'd1;
        end
        if (fin) m_done = 1;
        m_drained = old_done && was_empty;
        m_valid   = (mq.size() > 0) && (mq[0].edge_no < edge_no);
    endtask

    task automatic tick(input logic mw, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic ret, input logic [31:0] p);
        @(negedge clk);
        memwrite = mw; addr = a; wdata = d; out_ready = rdy; retire = ret; pc = p;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b0;
        memwrite = 0; addr = 0; wdata = 0; out_ready = 0; retire = 0; pc = 0;
        repeat (n) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        finish_pc = 32'h3C;
        reset = 1'b0;
        memwrite = 0; addr = 0; wdata = 0; out_ready = 1; retire = 0; pc = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if ({out_cycle, out_addr, out_data} !== 96'd0) begin fails++; $display("FAIL reset_out got %h want 0", {out_cycle, out_addr, out_data}); end
        tests++; if ({cycle_count, retire_count} !== 64'd0) begin fails++; $display("FAIL reset_counts got %h want 0", {cycle_count, retire_count}); end
        tests++; if ({done, drained, overflow, drop_count} !== 11'd0) begin fails++; $display("FAIL reset_flags got %h want 0", {done, drained, overflow, drop_count}); end
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_capture();
        logic mw;
        for (int c = 1; c <= 8; c++) begin
            mw = (c == 3) || (c == 7);
            tick(mw, (c == 3) ? 32'h54 : 32'h58, (c == 3) ? 32'h7 : 32'h9, 1'b1,
                 1'($urandom_range(0, 1)), 32'((c - 1) * 4));
            tests++; if (out_valid !== m_valid) begin fails++; $display("FAIL cap_valid c=%0d got %b want %b", c, out_valid, m_valid); end
            tests++; if (cycle_count !== m_cycle || retire_count !== m_retire) begin fails++; $display("FAIL cap_counts c=%0d got %0d/%0d want %0d/%0d", c, cycle_count, retire_count, m_cycle, m_retire); end
            if (c == 3) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL cap_no_bypass got %b want 0", out_valid); end
            end
            if (c == 4) begin
                tests++; if (out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== {32'd3, 32'h54, 32'h7}) begin fails++; $display("FAIL cap_entry1 got %b %h want 1 %h", out_valid, {out_cycle, out_addr, out_data}, {32'd3, 32'h54, 32'h7}); end
            end
            if (c == 8) begin
                tests++; if (out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== {32'd7, 32'h58, 32'h9}) begin fails++; $display("FAIL cap_entry2 got %b %h want 1 %h", out_valid, {out_cycle, out_addr, out_data}, {32'd7, 32'h58, 32'h9}); end
            end
        end
    endtask

    task automatic test_finish_freeze();
        for (int c = 9; c <= 16; c++) begin
            tick(c == 16, 32'h60, 32'hDEAD, 1'b1, 1'b1, 32'((c - 1) * 4));
            tests++; if (done !== m_done) begin fails++; $display("FAIL fin_done c=%0d got %b want %b", c, done, m_done); end
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL fin_done_set got %b want 1", done); end
        tests++; if (cycle_count !== 32'd15) begin fails++; $display("FAIL fin_cycle got %0d want 15", cycle_count); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fin_no_capture got %b want 0", out_valid); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 32'h64, 32'h1, 1'b1, 1'b1, 32'h40 + 32'(k * 4));
            tests++; if (cycle_count !== 32'd15 || retire_count !== m_retire) begin fails++; $display("FAIL fin_frozen got %0d/%0d want 15/%0d", cycle_count, retire_count, m_retire); end
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fin_valid_after got %b want 0", out_valid); end
        end
        tests++; if (drained !== 1'b1) begin fails++; $display("FAIL fin_drained got %b want 1", drained); end
    endtask

    task automatic test_backpressure();
        logic [95:0] first;
        logic [31:0] popped[$];
        apply_reset(2);
        for (int i = 1; i <= 4; i++) tick(1'b1, 32'h200 + 32'(i), 32'(i), 1'b0, 1'b0, 32'h0);
        first = {out_cycle, out_addr, out_data};
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            tests++; if (out_valid !== 1'b1 || {out_cycle, out_addr, out_data} !== first) begin fails++; $display("FAIL bp_stable got %b %h want 1 %h", out_valid, {out_cycle, out_addr, out_data}, first); end
        end
        tests++; if (first !== {32'd1, 32'h201, 32'd1}) begin fails++; $display("FAIL bp_head got %h want %h", first, {32'd1, 32'h201, 32'd1}); end
        for (int k = 0; k < 8; k++) begin
            if (out_valid) popped.push_back(out_data);
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            tests++; if (out_valid !== m_valid || (m_valid && {out_cycle, out_addr, out_data} !== {mq[0].cyc, mq[0].a, mq[0].d})) begin fails++; $display("FAIL bp_drain k=%0d got %b %h want %b", k, out_valid, {out_cycle, out_addr, out_data}, m_valid); end
        end
        tests++; if (popped.size() != 4) begin fails++; $display("FAIL bp_count got %0d want 4", popped.size()); end
        for (int i = 0; i < popped.size() && i < 4; i++) begin
            tests++; if (popped[i] !== 32'(i + 1)) begin fails++; $display("FAIL bp_order i=%0d got %0d want %0d", i, popped[i], i + 1); end
        end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL bp_overflow got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        apply_reset(2);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 32'h300, 32'h10 + 32'(i), 1'b0, 1'b0, 32'h0);
            if (i == 4) begin
                tests++; if (overflow !== 1'b1 || drop_count !== 8'd1) begin fails++; $display("FAIL ovf_first got %b/%0d want 1/1", overflow, drop_count); end
            end
        end
        tests++; if (overflow !== 1'b1 || drop_count !== 8'd2) begin fails++; $display("FAIL ovf_final got %b/%0d want 1/2", overflow, drop_count); end
        tests++; if (out_valid !== 1'b1 || out_data !== 32'h10) begin fails++; $display("FAIL ovf_head got %b/%h want 1/10", out_valid, out_data); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] popped[$];
        logic [31:0] want[4];
        want[0] = 32'h11; want[1] = 32'h12; want[2] = 32'h13; want[3] = 32'hAA;
        tick(1'b1, 32'h304, 32'hAA, 1'b1, 1'b0, 32'h0);
        tests++; if (drop_count !== 8'd2 || out_data !== 32'h11) begin fails++; $display("FAIL fpp_accept got %0d/%h want 2/11", drop_count, out_data); end
        tick(1'b1, 32'h308, 32'hBB, 1'b0, 1'b0, 32'h0);
        tests++; if (drop_count !== 8'd3) begin fails++; $display("FAIL fpp_still_full got %0d want 3", drop_count); end
        for (int k = 0; k < 8; k++) begin
            if (out_valid) popped.push_back(out_data);
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        tests++; if (popped.size() != 4) begin fails++; $display("FAIL fpp_count got %0d want 4", popped.size()); end
        for (int i = 0; i < popped.size() && i < 4; i++) begin
            tests++; if (popped[i] !== want[i]) begin fails++; $display("FAIL fpp_order i=%0d got %h want %h", i, popped[i], want[i]); end
        end
    endtask

    task automatic test_random();
        logic mw, rdy, ret;
        logic [31:0] p;
        apply_reset(2);
        for (int i = 0; i < 400; i++) begin
            mw  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 4);
            ret = 1'($urandom_range(0, 1));
            p   = (i == 350) ? 32'h3C : 32'h100 + 32'(i * 4);
            tick(mw, $urandom, $urandom, rdy, ret, p);
            tests++; if (out_valid !== m_valid || (m_valid && {out_cycle, out_addr, out_data} !== {mq[0].cyc, mq[0].a, mq[0].d})) begin fails++; $display("FAIL rnd_out i=%0d got %b %h want %b", i, out_valid, {out_cycle, out_addr, out_data}, m_valid); end
            tests++; if (cycle_count !== m_cycle || retire_count !== m_retire) begin fails++; $display("FAIL rnd_counts i=%0d got %0d/%0d want %0d/%0d", i, cycle_count, retire_count, m_cycle, m_retire); end
            tests++; if ({done, drained, overflow, drop_count} !== {m_done, m_drained, m_overflow, m_drop}) begin fails++; $display("FAIL rnd_flags i=%0d got %h want %h", i, {done, drained, overflow, drop_count}, {m_done, m_drained, m_overflow, m_drop}); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(2);
        for (int i = 0; i < 3; i++) tick(1'b1, 32'h400, 32'h50 + 32'(i), 1'b0, 1'b1, 32'h0);
        tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3C);
        tests++; if (done !== 1'b1 || out_valid !== 1'b1 || retire_count !== 32'd3) begin fails++; $display("FAIL ar_pre got %b/%b/%0d want 1/1/3", done, out_valid, retire_count); end
        #2 reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL ar_flags got %b/%b want 0/0", out_valid, done); end
        tests++; if (cycle_count !== 32'd0 || retire_count !== 32'd0) begin fails++; $display("FAIL ar_counts got %0d/%0d want 0/0", cycle_count, retire_count); end
        tests++; if ({out_cycle, out_addr, out_data} !== 96'd0) begin fails++; $display("FAIL ar_out got %h want 0", {out_cycle, out_addr, out_data}); end
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
            tests++; if (out_valid !== 1'b0 || cycle_count !== m_cycle) begin fails++; $display("FAIL ar_after k=%0d got %b/%0d want 0/%0d", k, out_valid, cycle_count, m_cycle); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_finish_freeze();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
